// File: rtl/button_debounce_ctrl.sv
// Single-button debouncer: 2-flop synchroniser feeding a tick-sampled qualification FSM,
// with a registered clean level and one-cycle press/release pulses.
module button_debounce_ctrl #(
    parameter int TICK_DIV       = 40000,
    parameter int STABLE_SAMPLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_in,
    output logic btn_level,
    output logic btn_press,
    output logic btn_release,
    output logic busy
);

    localparam int TW = $clog2(TICK_DIV);
    localparam int AW = $clog2(STABLE_SAMPLES + 1);
    localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_DIV - 1);
    localparam logic [AW-1:0] AGREE_LAST = AW'(STABLE_SAMPLES - 1);
    localparam logic [AW-1:0] AGREE_MAX  = AW'(STABLE_SAMPLES);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CHK_HI = 2'd1,
        HIGH   = 2'd2,
        CHK_LO = 2'd3
    } state_t;

    state_t        state;
    state_t        next_state;
    logic [1:0]    sync_ff;
    logic          sync;
    logic [TW-1:0] timer;
    logic [AW-1:0] agree;
    logic          in_chk;
    logic          tick;
    logic          sample_agrees;
    logic          level_d;
    logic          press_d;
    logic          release_d;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_ff <= 2'b00;
        end else begin
            sync_ff <= {sync_ff[0], btn_in};
        end
    end

    assign sync          = sync_ff[1];
    assign in_chk        = (state == CHK_HI) || (state == CHK_LO);
    assign tick          = in_chk && (timer == TICK_LAST);
    // In CHK_HI a high sample agrees; in CHK_LO a low sample agrees.
    assign sample_agrees = (sync == (state == CHK_HI));
    assign busy          = in_chk;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        // NOTE: defaults come first so no branch leaves a signal unassigned (no latch).
        next_state = state;
        case (state)
            IDLE: begin
                if (sync) next_state = CHK_HI;
            end
            CHK_HI: begin
                if (tick) begin
                    if (!sync)                    next_state = IDLE;
                    else if (agree == AGREE_LAST) next_state = HIGH;
                end
            end
            HIGH: begin
                if (!sync) next_state = CHK_LO;
            end
            CHK_LO: begin
                if (tick) begin
                    if (sync)                     next_state = HIGH;
                    else if (agree == AGREE_LAST) next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
        level_d   = (next_state == HIGH) || (next_state == CHK_LO);
        press_d   = (state == CHK_HI) && (next_state == HIGH);
        release_d = (state == CHK_LO) && (next_state == IDLE);
    end

    // Timer and agree count restart on any state change, so each qualification starts clean.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer <= '0;
            agree <= '0;
        end else if (!in_chk || (next_state != state)) begin
            timer <= '0;
            agree <= '0;
        end else begin
            timer <= tick ? '0 : timer + 1'b1;
            if (tick && sample_agrees && (agree != AGREE_MAX)) begin
                agree <= agree + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_level   <= 1'b0;
            btn_press   <= 1'b0;
            btn_release <= 1'b0;
        end else begin
            btn_level   <= level_d;
            btn_press   <= press_d;
            btn_release <= release_d;
        end
    end

endmodule

// File: tb/tb_button_debounce_ctrl.sv
// Bench for button_debounce_ctrl: three parameter sets driven by one input, each checked
// every cycle against an edge-arithmetic reference model plus directed timing points.
module tb_button_debounce_ctrl;

    logic clk;
    logic rst_n;
    logic btn_in;

    logic level_a, press_a, release_a, busy_a;
    logic level_b, press_b, release_b, busy_b;
    logic level_c, press_c, release_c, busy_c;

    int n_checks;
    int n_fail;

    button_debounce_ctrl #(.TICK_DIV(10), .STABLE_SAMPLES(3)) dut_a (
        .clk(clk), .rst_n(rst_n), .btn_in(btn_in),
        .btn_level(level_a), .btn_press(press_a), .btn_release(release_a), .busy(busy_a)
    );

    button_debounce_ctrl #(.TICK_DIV(2), .STABLE_SAMPLES(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .btn_in(btn_in),
        .btn_level(level_b), .btn_press(press_b), .btn_release(release_b), .busy(busy_b)
    );

    button_debounce_ctrl #(.TICK_DIV(1000), .STABLE_SAMPLES(4)) dut_c (
        .clk(clk), .rst_n(rst_n), .btn_in(btn_in),
        .btn_level(level_c), .btn_press(press_c), .btn_release(release_c), .busy(busy_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a qualification started at edge e0 samples at edges e0+k*T
    // (k = 1..S); any disagreeing sample aborts, S agreeing samples accept.
    typedef struct {
        int ecount;
        bit s_a;
        bit s;
        bit level;
        bit qual;
        int start;
        bit press;
        bit rel;
    } model_t;

    model_t ma, mb, mc;

    function automatic model_t model_reset();
        model_t m;
        m = '{default: 0};
        return m;
    endfunction

    function automatic model_t model_step(model_t m_in, bit b, int td, int ns);
        model_t m;
        bit     target;
        int     elapsed;
        m       = m_in;
        m.press = 1'b0;
        m.rel   = 1'b0;
        target  = !m.level;
        if (m.qual) begin
            elapsed = m.ecount - m.start;
            if (elapsed % td == 0) begin
                if (m.s != target) begin
                    m.qual = 1'b0;
                end else if (elapsed / td == ns) begin
                    m.qual  = 1'b0;
                    m.level = target;
                    m.press = target;
                    m.rel   = !target;
                end
            end
        end else if (m.s != m.level) begin
            m.qual  = 1'b1;
            m.start = m.ecount;
        end
        m.s      = m.s_a;
        m.s_a    = b;
        m.ecount = m.ecount + 1;
        return m;
    endfunction

    task automatic check(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        check("a_level",   level_a,   ma.level);
        check("a_press",   press_a,   ma.press);
        check("a_release", release_a, ma.rel);
        check("a_busy",    busy_a,    ma.qual);
        check("b_level",   level_b,   mb.level);
        check("b_press",   press_b,   mb.press);
        check("b_release", release_b, mb.rel);
        check("b_busy",    busy_b,    mb.qual);
        check("c_level",   level_c,   mc.level);
        check("c_press",   press_c,   mc.press);
        check("c_release", release_c, mc.rel);
        check("c_busy",    busy_c,    mc.qual);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_a_level"},   level_a,   1'b0);
        check({tag, "_a_press"},   press_a,   1'b0);
        check({tag, "_a_release"}, release_a, 1'b0);
        check({tag, "_a_busy"},    busy_a,    1'b0);
        check({tag, "_b_level"},   level_b,   1'b0);
        check({tag, "_b_busy"},    busy_b,    1'b0);
        check({tag, "_c_level"},   level_c,   1'b0);
        check({tag, "_c_busy"},    busy_c,    1'b0);
    endtask

    task automatic models_reset();
        ma = model_reset();
        mb = model_reset();
        mc = model_reset();
    endtask

    // One clock edge with btn_in = b, then compare all outputs to the models.
    task automatic step(input bit b);
        btn_in = b;
        @(posedge clk);
        ma = model_step(ma, b, 10, 3);
        mb = model_step(mb, b, 2, 1);
        mc = model_step(mc, b, 1000, 4);
        #1;
        check_all();
    endtask

    task automatic run(input bit b, input int n);
        for (int i = 0; i < n; i++) step(b);
    endtask

    initial begin
        int busy_cnt;
        n_checks = 0;
        n_fail   = 0;
        btn_in   = 1'b0;
        rst_n    = 1'b0;
        models_reset();

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        run(1'b0, 5);

        // Clean press: edge 0 is the first edge sampling 1
        for (int e = 0; e <= 33; e++) begin
            step(1'b1);
            if (e == 1)  check("press_a_busy_e1", busy_a, 1'b0);
            if (e == 2)  check("press_a_busy_e2", busy_a, 1'b1);
            if (e == 31) check("press_a_level_e31", level_a, 1'b0);
            if (e == 32) begin
                check("press_a_pulse_e32", press_a, 1'b1);
                check("press_a_level_e32", level_a, 1'b1);
            end
            if (e == 33) check("press_a_pulse_e33", press_a, 1'b0);
            if (e == 3)  check("press_b_level_e3", level_b, 1'b0);
            if (e == 4)  check("press_b_pulse_e4", press_b, 1'b1);
            if (e == 5)  check("press_b_pulse_e5", press_b, 1'b0);
        end
        run(1'b1, 5);

        // Release from HIGH
        for (int e = 0; e <= 33; e++) begin
            step(1'b0);
            if (e == 2)  check("rel_a_busy_e2", busy_a, 1'b1);
            if (e == 31) check("rel_a_level_e31", level_a, 1'b1);
            if (e == 32) begin
                check("rel_a_pulse_e32", release_a, 1'b1);
                check("rel_a_level_e32", level_a, 1'b0);
            end
            if (e == 33) check("rel_a_pulse_e33", release_a, 1'b0);
            if (e == 4)  check("rel_b_pulse_e4", release_b, 1'b1);
        end
        run(1'b0, 5);

        // Bounce abort: low samples at edges 15..24, abort at edge 22, re-qualify from edge 27
        for (int e = 0; e <= 58; e++) begin
            step((e >= 15 && e <= 24) ? 1'b0 : 1'b1);
            if (e == 21) check("bounce_a_busy_e21", busy_a, 1'b1);
            if (e == 22) begin
                check("bounce_a_busy_e22", busy_a, 1'b0);
                check("bounce_a_level_e22", level_a, 1'b0);
            end
            if (e == 27) check("bounce_a_busy_e27", busy_a, 1'b1);
            if (e == 56) check("bounce_a_level_e56", level_a, 1'b0);
            if (e == 57) check("bounce_a_press_e57", press_a, 1'b1);
        end

        // Sub-tick glitch in HIGH: 4 low samples, aborting tick before edge 12
        for (int e = 0; e <= 15; e++) begin
            step((e <= 3) ? 1'b0 : 1'b1);
            if (e == 11) check("glitch_a_busy_e11", busy_a, 1'b1);
            if (e == 12) begin
                check("glitch_a_busy_e12", busy_a, 1'b0);
                check("glitch_a_level_e12", level_a, 1'b1);
            end
        end
        run(1'b0, 40);

        // Async reset mid-qualification, then re-qualify from scratch
        run(1'b1, 22);
        #3;
        rst_n = 1'b0;
        #1;
        check_zero("async_rst");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        models_reset();
        for (int e = 0; e <= 33; e++) begin
            step(1'b1);
            if (e == 31) check("rst_a_press_e31", press_a, 1'b0);
            if (e == 32) check("rst_a_press_e32", press_a, 1'b1);
        end

        // Randomized level segments: short glitches, mid holds and full qualifications
        for (int seg = 0; seg < 60; seg++) begin
            bit lvl;
            int len;
            lvl = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 2))
                0:       len = $urandom_range(1, 8);
                1:       len = $urandom_range(9, 25);
                default: len = $urandom_range(35, 60);
            endcase
            run(lvl, len);
        end

        // Default sample count with a long period: press at edge 2+4*1000, busy 4000 cycles
        run(1'b0, 4100);
        busy_cnt = 0;
        for (int e = 0; e <= 4003; e++) begin
            step(1'b1);
            if (busy_c) busy_cnt++;
            if (e == 4001) check("long_c_level_e4001", level_c, 1'b0);
            if (e == 4002) check("long_c_press_e4002", press_c, 1'b1);
            if (e == 4003) check("long_c_press_e4003", press_c, 1'b0);
        end
        check_int("long_c_busy_cycles", busy_cnt, 4000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
